// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: direction/output registers, synchronised pin sampling,
// per-bit edge-selectable interrupt status with write-one-to-clear, and a
// registered read port.
module gpio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DIR    = 3'd0;
    localparam logic [2:0] ADDR_DOUT   = 3'd1;
    localparam logic [2:0] ADDR_PIN    = 3'd2;
    localparam logic [2:0] ADDR_IE     = 3'd3;
    localparam logic [2:0] ADDR_EDGE   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] status_set;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] rd_mux;

    // Pads drive straight from the registers; no extra gating.
    assign io_oe  = dir_q;
    assign io_out = dout_q;
    assign irq    = |(status_q & ie_q);

    assign pin = sync_q[SYNC_STAGES-1];

    // Event: selected transition between history and synchroniser output.
    // Only input-direction, enabled bits may latch into STATUS.
    assign evt        = (edge_q & pin & ~hist_q) | (~edge_q & ~pin & hist_q);
    assign status_set = evt & ~dir_q & ie_q;
    assign status_clr = (wr_en && addr == ADDR_STATUS) ? wr_data : '0;

    // Pad synchroniser chain plus one-cycle history of its output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= pin;
        end
    end

    // Configuration registers; PIN and unmapped addresses ignore writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q  <= '0;
            dout_q <= '0;
            ie_q   <= '0;
            edge_q <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_DIR:  dir_q  <= wr_data;
                ADDR_DOUT: dout_q <= wr_data;
                ADDR_IE:   ie_q   <= wr_data;
                ADDR_EDGE: edge_q <= wr_data;
                default:   ;
            endcase
        end
    end

    // Sticky status: write-one-to-clear, a same-cycle set beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_q <= '0;
        else     status_q <= (status_q & ~status_clr) | status_set;
    end

    // Read mux sees the pre-edge register values, so a read that coincides
    // with a write to the same address returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DIR:    rd_mux = dir_q;
            ADDR_DOUT:   rd_mux = dout_q;
            ADDR_PIN:    rd_mux = pin;
            ADDR_IE:     rd_mux = ie_q;
            ADDR_EDGE:   rd_mux = edge_q;
            ADDR_STATUS: rd_mux = status_q;
            default:     rd_mux = '0;
        endcase
    end

    // Read handshake: rd_en sampled high at edge k gives rd_valid=1 with
    // rd_data for the whole following cycle; there is no back-pressure, and
    // rd_data holds its last value while rd_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: directed scenarios followed by a random phase,
// all checked against a register-level reference model.
module tb_gpio_port_ctrl;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   addr;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic [W-1:0] io_in;
    logic [W-1:0] io_out;
    logic [W-1:0] io_oe;
    logic         irq;

    int n_checks = 0;
    int n_pass   = 0;

    gpio_port_ctrl #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .irq(irq)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // in_q[0] is the newest io_in sample taken at a rising edge; the pin
    // value a reader sees is the sample taken SS-1 edges before the newest.
    logic [W-1:0] m_dir, m_dout, m_ie, m_edge, m_status, m_rd_data;
    logic         m_rd_valid;
    logic [W-1:0] in_q[$];
    logic [W-1:0] m_pin, m_prev, m_set;

    function automatic logic [W-1:0] m_reg(input logic [2:0] a, input logic [W-1:0] p);
        case (a)
            3'd0: return m_dir;
            3'd1: return m_dout;
            3'd2: return p;
            3'd3: return m_ie;
            3'd4: return m_edge;
            3'd5: return m_status;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dir = '0; m_dout = '0; m_ie = '0; m_edge = '0; m_status = '0;
            m_rd_data = '0; m_rd_valid = 1'b0;
            in_q = {};
            repeat (SS + 1) in_q.push_front('0);
        end else begin
            m_pin  = in_q[SS-1];
            m_prev = in_q[SS];
            m_set  = '0;
            for (int i = 0; i < W; i++) begin
                if (m_dir[i] == 1'b0 && m_ie[i] == 1'b1) begin
                    if (m_edge[i] && !m_prev[i] && m_pin[i]) m_set[i] = 1'b1;
                    if (!m_edge[i] && m_prev[i] && !m_pin[i]) m_set[i] = 1'b1;
                end
            end
            m_rd_valid = rd_en;
            if (rd_en) m_rd_data = m_reg(addr, m_pin);
            if (wr_en) begin
                case (addr)
                    3'd0: m_dir  = wr_data;
                    3'd1: m_dout = wr_data;
                    3'd3: m_ie   = wr_data;
                    3'd4: m_edge = wr_data;
                    3'd5: m_status = m_status & ~wr_data;
                    default: ;
                endcase
            end
            m_status = m_status | m_set;
            in_q.push_front(io_in);
            void'(in_q.pop_back());
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model();
        check("model_io_oe", io_oe, m_dir);
        check("model_io_out", io_out, m_dout);
        check("model_irq", {7'd0, irq}, {7'd0, |(m_status & m_ie)});
        check("model_rd_valid", {7'd0, rd_valid}, {7'd0, m_rd_valid});
        check("model_rd_data", rd_data, m_rd_data);
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [W-1:0] exp, input string tag);
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_valid"}, {7'd0, rd_valid}, 8'd1);
        tick();
        check({tag, "_valid_drop"}, {7'd0, rd_valid}, 8'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; io_in = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_io_oe", io_oe, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'd0);
        check("rst_rd_valid", {7'd0, rd_valid}, 8'd0);
        rst = 1'b0;

        // reset release, pin appears after two edges
        check("rel_io_oe", io_oe, 8'h00);
        ticks(2);
        read_reg(3'd2, 8'hFF, "pin_ff");
        read_reg(3'd5, 8'h00, "status_after_rst");
        check("rel_irq", {7'd0, irq}, 8'd0);

        // direction / output data
        write_reg(3'd0, 8'hF0);
        check("dir_io_oe", io_oe, 8'hF0);
        write_reg(3'd1, 8'hAA);
        check("dout_io_out", io_out, 8'hAA);
        read_reg(3'd0, 8'hF0, "dir_read");

        // ignored writes and unmapped reads
        write_reg(3'd2, 8'h00);
        write_reg(3'd6, 8'h5A);
        write_reg(3'd7, 8'h5A);
        read_reg(3'd2, 8'hFF, "pin_wr_ignored");
        read_reg(3'd6, 8'h00, "unmapped6");
        read_reg(3'd7, 8'h00, "unmapped7");
        check("unmapped_dir_kept", io_oe, 8'hF0);

        // simultaneous read and write returns the old value
        rd_en = 1'b1; wr_en = 1'b1; addr = 3'd1; wr_data = 8'h55;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check("rw_same_old", rd_data, 8'hAA);
        check("rw_same_new_out", io_out, 8'h55);
        write_reg(3'd1, 8'hAA);

        // rising edge on bit 0: status two edges after the change
        io_in = 8'h00;
        ticks(4);
        write_reg(3'd3, 8'h01);
        write_reg(3'd4, 8'h01);
        io_in = 8'h01;
        tick();
        check("rise0_e0_irq", {7'd0, irq}, 8'd0);
        tick();
        check("rise0_e1_irq", {7'd0, irq}, 8'd0);
        tick();
        check("rise0_e2_irq", {7'd0, irq}, 8'd1);
        read_reg(3'd5, 8'h01, "rise0_status");
        write_reg(3'd5, 8'h01);
        check("w1c_irq", {7'd0, irq}, 8'd0);

        // falling edge on bit 3: suppressed while bit 3 is an output
        write_reg(3'd0, 8'hF8);
        write_reg(3'd3, 8'h08);
        write_reg(3'd4, 8'h00);
        io_in = 8'h09; ticks(4);
        io_in = 8'h01; ticks(4);
        read_reg(3'd5, 8'h00, "fall3_dir_out");
        write_reg(3'd0, 8'hF0);
        io_in = 8'h09; ticks(4);
        read_reg(3'd5, 8'h00, "fall3_on_rise");
        io_in = 8'h01; ticks(4);
        check("fall3_irq", {7'd0, irq}, 8'd1);
        read_reg(3'd5, 8'h08, "fall3_status");
        write_reg(3'd3, 8'h00);
        check("ie_mask_irq", {7'd0, irq}, 8'd0);
        read_reg(3'd5, 8'h08, "ie_mask_status_kept");
        write_reg(3'd5, 8'h08);

        // event coinciding with W1C: set wins; writing 0 does not clear
        write_reg(3'd3, 8'h01);
        write_reg(3'd4, 8'h01);
        io_in = 8'h00; ticks(4);
        io_in = 8'h01;
        ticks(2);
        write_reg(3'd5, 8'h01);
        check("set_wins_irq", {7'd0, irq}, 8'd1);
        write_reg(3'd5, 8'h00);
        read_reg(3'd5, 8'h01, "set_wins_status");
        write_reg(3'd5, 8'h01);

        // changing EDGE / DIR on a stable input sets nothing
        write_reg(3'd0, 8'h00);
        write_reg(3'd3, 8'hFF);
        write_reg(3'd4, 8'h00);
        write_reg(3'd4, 8'hFF);
        write_reg(3'd0, 8'hFF);
        write_reg(3'd0, 8'h00);
        ticks(3);
        read_reg(3'd5, 8'h00, "cfg_change_no_set");

        // random phase
        for (int n = 0; n < 400; n++) begin
            io_in   = W'($urandom);
            addr    = 3'($urandom_range(0, 7));
            wr_data = W'($urandom);
            wr_en   = ($urandom_range(0, 3) == 0);
            rd_en   = ($urandom_range(0, 1) == 0);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // asynchronous reset while irq and rd_valid are high
        write_reg(3'd0, 8'h00);
        write_reg(3'd3, 8'h01);
        write_reg(3'd4, 8'h01);
        io_in = 8'h00; ticks(4);
        write_reg(3'd5, 8'hFF);
        write_reg(3'd1, 8'hC3);
        io_in = 8'h01; ticks(3);
        rd_en = 1'b1; addr = 3'd1;
        @(posedge clk); #1;
        check("pre_rst_irq", {7'd0, irq}, 8'd1);
        check("pre_rst_rd_valid", {7'd0, rd_valid}, 8'd1);
        check("pre_rst_rd_data", rd_data, 8'hC3);
        rst = 1'b1;
        #1;
        check("async_rst_io_out", io_out, 8'h00);
        check("async_rst_irq", {7'd0, irq}, 8'd0);
        check("async_rst_rd_valid", {7'd0, rd_valid}, 8'd0);
        check("async_rst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0;
        write_reg(3'd0, 8'h3C);
        check("post_rst_first_write", io_oe, 8'h3C);
        read_reg(3'd3, 8'h00, "post_rst_ie");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_port_ctrl.md
GPIO_PORT_CTRL -- requirements
Module: gpio_port_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of port bits.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, sets the input synchroniser depth.
REQ-003 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 ADDR  in  3  register select.
REQ-007 WR_EN  in  1  write strobe, sampled at the rising edge.
REQ-008 RD_EN  in  1  read strobe, sampled at the rising edge.
REQ-009 WR_DATA  in  WIDTH  write data.
REQ-010 RD_DATA  out  WIDTH  registered read data.
REQ-011 RD_VALID  out  1  high for one cycle when RD_DATA is valid.
REQ-012 IO_IN  in  WIDTH  asynchronous pad inputs.
REQ-013 IO_OUT  out  WIDTH  output data to the pad tri-state drivers.
REQ-014 IO_OE  out  WIDTH  per-bit output enable; 1 = drive the pad.
REQ-015 IRQ  out  1  interrupt request, level-high.

Function
REQ-016 Register map SHALL be: 0 DIR (RW), 1 DOUT (RW), 2 PIN (RO), 3 IE (RW), 4 EDGE (RW; 1 = rising, 0 = falling), 5 STATUS (W1C); addresses 6-7 are unmapped.
REQ-017 IO_OE SHALL equal DIR and IO_OUT SHALL equal DOUT, combinationally from the registers, with no extra gating.
REQ-018 A write SHALL take effect at the rising edge where WR_EN=1, so IO_OE/IO_OUT change in that same cycle.
REQ-019 Writes to PIN and to unmapped addresses SHALL be ignored.
REQ-020 A read with RD_EN=1 at edge k SHALL present data on RD_DATA with RD_VALID=1 after edge k; RD_VALID SHALL drop after edge k+1 unless RD_EN is held.
REQ-021 Unmapped reads SHALL return 0 with RD_VALID=1.
REQ-022 A simultaneous read and write to the same address SHALL return the pre-write value.
REQ-023 IO_IN SHALL pass through a SYNC_STAGES-deep flop chain per bit; PIN SHALL return the synchroniser output for every bit, regardless of DIR.
REQ-024 A history register SHALL hold the previous synchroniser output.
REQ-025 An event on bit i SHALL be: a 0->1 transition when EDGE[i]=1, or a 1->0 transition when EDGE[i]=0, detected as sync != history.
REQ-026 STATUS[i] SHALL set only when an event occurs, DIR[i]=0 and IE[i]=1; it then SHALL stay set until cleared.
REQ-027 Writing 1 to STATUS bit i SHALL clear it; writing 0 SHALL have no effect.
REQ-028 If a set and a clear of the same bit coincide in one cycle, set SHALL win.
REQ-029 With SYNC_STAGES=2, an IO_IN change stable before edge k SHALL appear in PIN after edge k+1 and set STATUS after edge k+2.
REQ-030 IRQ SHALL equal the OR-reduction of (STATUS & IE), combinationally.
REQ-031 Clearing IE[i] SHALL immediately mask bit i from IRQ without clearing STATUS[i].
REQ-032 Changing EDGE or DIR SHALL NOT by itself set STATUS.

Reset
REQ-033 While RST=1, DIR, DOUT, IE, EDGE, STATUS, the synchroniser, the history register, RD_DATA and RD_VALID SHALL all be 0, so IO_OE=0, IO_OUT=0 and IRQ=0.
REQ-034 Assertion of RST mid-operation SHALL clear all state immediately, without waiting for CLK.
REQ-035 The first register access SHALL be accepted at the first rising edge after RST falls.

Verification
REQ-036 Reset with IO_IN=8'hFF, then release -> IO_OE=0, IRQ=0, STATUS reads 0, PIN reads 8'hFF after two edges.
REQ-037 Write DIR=8'hF0, DOUT=8'hAA -> IO_OE=8'hF0 and IO_OUT=8'hAA; DIR readback gives RD_DATA=8'hF0 with a single-cycle RD_VALID.
REQ-038 IE=8'h01, EDGE=8'h01, IO_IN[0] toggles 0->1 -> STATUS=8'h01 exactly two edges later, IRQ=1; write STATUS=8'h01 -> IRQ=0.
REQ-039 Falling-edge mode on bit 3 with DIR[3]=1 -> no STATUS set; with DIR[3]=0 -> STATUS[3]=1 on the 1->0 transition only.
REQ-040 Event on bit 0 in the same cycle as a W1C of bit 0 -> STATUS[0] remains 1.
REQ-041 Assert RST while IRQ=1 and RD_VALID=1 -> all outputs are 0 before the next CLK edge.
